// File: rtl/bexkat1_idecode.sv
// bexkat1 decode stage: splits the fetched word into fields, builds the immediate,
// stalls fetch on read-after-write hazards and registers the result into ID/EX.
module bexkat1_idecode #(
  parameter int          NREG_BITS = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [63:0]          ir_i,
  input  logic [31:0]          pc_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 ex_wvalid_i,
  input  logic [NREG_BITS-1:0] ex_wreg_i,
  input  logic                 mem_wvalid_i,
  input  logic [NREG_BITS-1:0] mem_wreg_i,
  output logic                 stall_o,
  output logic [NREG_BITS-1:0] rf_raddr0_o,
  output logic [NREG_BITS-1:0] rf_raddr1_o,
  output logic                 valid_o,
  output logic [3:0]           type_o,
  output logic [3:0]           op_o,
  output logic [NREG_BITS-1:0] ra_o,
  output logic [NREG_BITS-1:0] rb_o,
  output logic [NREG_BITS-1:0] rc_o,
  output logic [31:0]          imm_o,
  output logic                 wen_o,
  output logic                 exc_o,
  output logic [31:0]          pc_o
);

  logic [31:0]          ir_lo;
  logic                 d_bubble;
  logic [3:0]           d_type;
  logic [3:0]           d_op;
  logic [NREG_BITS-1:0] d_ra;
  logic [NREG_BITS-1:0] d_rb;
  logic [NREG_BITS-1:0] d_rc;
  logic [31:0]          d_imm;
  logic                 d_wen;
  logic                 d_exc;
  logic [2:0]           src_rd;
  logic [2:0]           src_hit;
  logic [NREG_BITS-1:0] src_reg [3];
  logic                 hazard;

  logic                 valid_reg;
  logic [3:0]           type_reg;
  logic [3:0]           op_reg;
  logic [NREG_BITS-1:0] ra_reg;
  logic [NREG_BITS-1:0] rb_reg;
  logic [NREG_BITS-1:0] rc_reg;
  logic [31:0]          imm_reg;
  logic                 wen_reg;
  logic                 exc_reg;
  logic [31:0]          pc_reg;

  assign ir_lo    = ir_i[31:0];
  assign d_bubble = (ir_lo == 32'h0);
  assign d_type   = ir_lo[31:28];
  assign d_op     = ir_lo[27:24];
  assign d_ra     = ir_lo[20 +: NREG_BITS];
  assign d_rb     = ir_lo[16 +: NREG_BITS];
  assign d_rc     = ir_lo[12 +: NREG_BITS];
  assign d_imm    = ir_lo[0] ? ir_i[63:32] : {{21{ir_lo[11]}}, ir_lo[11:1]};

  // src_rd bit order: {rc, rb, ra}
  always_comb begin
    src_rd = 3'b000;
    d_wen  = 1'b0;
    d_exc  = 1'b0;
    if (!d_bubble) begin
      case (d_type)
        4'd0: ;
        4'd1: begin src_rd = 3'b110; d_wen = 1'b1; end
        4'd2: begin src_rd = 3'b010; d_wen = 1'b1; end
        4'd3: src_rd = 3'b011;
        4'd4: begin src_rd = 3'b010; d_wen = 1'b1; end
        4'd5: d_wen = 1'b1;
        4'd6: src_rd = 3'b011;
        default: d_exc = 1'b1;
      endcase
    end
  end

  assign src_reg[0] = d_ra;
  assign src_reg[1] = d_rb;
  assign src_reg[2] = d_rc;

  // No forwarding: any in-flight writer of a source register forces a stall.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      assign src_hit[gi] = src_rd[gi] &
        ((valid_reg & wen_reg & (ra_reg == src_reg[gi])) |
         (ex_wvalid_i & (ex_wreg_i == src_reg[gi])) |
         (mem_wvalid_i & (mem_wreg_i == src_reg[gi])));
    end
  endgenerate

  assign hazard      = |src_hit;
  assign stall_o     = stall_i | (hazard & ~flush_i);
  assign rf_raddr0_o = d_rb;
  assign rf_raddr1_o = ((d_type == 4'd3) || (d_type == 4'd6)) ? d_ra : d_rc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_reg <= 1'b0;
      type_reg  <= 4'h0;
      op_reg    <= 4'h0;
      ra_reg    <= '0;
      rb_reg    <= '0;
      rc_reg    <= '0;
      imm_reg   <= 32'h0;
      wen_reg   <= 1'b0;
      exc_reg   <= 1'b0;
      pc_reg    <= RESET_PC;
    end else if (flush_i || (!stall_i && hazard)) begin
      // Bubble: fields cleared, pc kept
      valid_reg <= 1'b0;
      type_reg  <= 4'h0;
      op_reg    <= 4'h0;
      ra_reg    <= '0;
      rb_reg    <= '0;
      rc_reg    <= '0;
      imm_reg   <= 32'h0;
      wen_reg   <= 1'b0;
      exc_reg   <= 1'b0;
    end else if (!stall_i) begin
      valid_reg <= ~d_bubble;
      type_reg  <= d_type;
      op_reg    <= d_op;
      ra_reg    <= d_ra;
      rb_reg    <= d_rb;
      rc_reg    <= d_rc;
      imm_reg   <= d_bubble ? 32'h0 : d_imm;
      wen_reg   <= d_wen;
      exc_reg   <= d_exc;
      if (!d_bubble)
        pc_reg <= pc_i;
    end
  end

  assign valid_o = valid_reg;
  assign type_o  = type_reg;
  assign op_o    = op_reg;
  assign ra_o    = ra_reg;
  assign rb_o    = rb_reg;
  assign rc_o    = rc_reg;
  assign imm_o   = imm_reg;
  assign wen_o   = wen_reg;
  assign exc_o   = exc_reg;
  assign pc_o    = pc_reg;

endmodule

// File: tb/tb_bexkat1_idecode.sv
// Self-checking bench for bexkat1_idecode: vector table plus load-use and reset sequences.
module tb_bexkat1_idecode;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ir;
  logic [31:0] pc;
  logic        st, fl;
  logic        tb_exv, tb_mv;
  logic [3:0]  tb_exr, tb_mr;
  logic        fb_en;
  logic        fb_ex_v, fb_m_v;
  logic [3:0]  fb_ex_r, fb_m_r;
  logic        ex_wvalid, mem_wvalid;
  logic [3:0]  ex_wreg, mem_wreg;

  logic        stall_o, valid_o, wen_o, exc_o;
  logic [3:0]  raddr0, raddr1, type_o, op_o, ra_o, rb_o, rc_o;
  logic [31:0] imm_o, pc_o;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  assign ex_wvalid  = fb_en ? fb_ex_v : tb_exv;
  assign ex_wreg    = fb_en ? fb_ex_r : tb_exr;
  assign mem_wvalid = fb_en ? fb_m_v  : tb_mv;
  assign mem_wreg   = fb_en ? fb_m_r  : tb_mr;

  // Stand-in for EX and MEM: each holds the ID/EX writer for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_ex_v <= 1'b0; fb_ex_r <= 4'h0; fb_m_v <= 1'b0; fb_m_r <= 4'h0;
    end else begin
      fb_ex_v <= valid_o & wen_o; fb_ex_r <= ra_o;
      fb_m_v  <= fb_ex_v;         fb_m_r  <= fb_ex_r;
    end
  end

  bexkat1_idecode #(.NREG_BITS(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .ir_i(ir), .pc_i(pc), .stall_i(st), .flush_i(fl),
    .ex_wvalid_i(ex_wvalid), .ex_wreg_i(ex_wreg),
    .mem_wvalid_i(mem_wvalid), .mem_wreg_i(mem_wreg),
    .stall_o(stall_o), .rf_raddr0_o(raddr0), .rf_raddr1_o(raddr1),
    .valid_o(valid_o), .type_o(type_o), .op_o(op_o),
    .ra_o(ra_o), .rb_o(rb_o), .rc_o(rc_o), .imm_o(imm_o),
    .wen_o(wen_o), .exc_o(exc_o), .pc_o(pc_o)
  );

  typedef struct {
    logic [63:0] ir;
    logic [31:0] pc;
    logic        st, fl, exv;
    logic [3:0]  exr;
    logic        mv;
    logic [3:0]  mr;
    logic [8:0]  pre;
    logic [86:0] post;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  logic [86:0] exp_q [$];

  function automatic logic [86:0] post_f(logic v, logic [3:0] t, logic [3:0] o,
      logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [31:0] imm,
      logic w, logic e, logic [31:0] p);
    return {v, t, o, a, b, c, imm, w, e, p};
  endfunction

  function automatic logic [86:0] bub(logic [31:0] p);
    return post_f(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, p);
  endfunction

  function automatic vec_t mkv(logic [63:0] i, logic [31:0] p, logic s, logic f,
      logic xv, logic [3:0] xr, logic mvv, logic [3:0] mrr, logic [8:0] pr,
      logic [86:0] po);
    vec_t r;
    r.ir = i; r.pc = p; r.st = s; r.fl = f; r.exv = xv; r.exr = xr;
    r.mv = mvv; r.mr = mrr; r.pre = pr; r.post = po;
    return r;
  endfunction

  function automatic logic [86:0] act_post();
    return {valid_o, type_o, op_o, ra_o, rb_o, rc_o, imm_o, wen_o, exc_o, pc_o};
  endfunction

  task automatic chk(string nm, logic [86:0] act, logic [86:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic apply(string nm, logic [63:0] i, logic [31:0] p, logic s, logic f,
      logic xv, logic [3:0] xr, logic mvv, logic [3:0] mrr, logic [8:0] pr,
      logic [86:0] po);
    logic [86:0] e;
    @(negedge clk);
    ir = i; pc = p; st = s; fl = f; tb_exv = xv; tb_exr = xr; tb_mv = mvv; tb_mr = mrr;
    exp_q.push_back(po);
    #1;
    chk({nm, "_pre"}, {78'h0, stall_o, raddr0, raddr1}, {78'h0, pr});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({nm, "_post"}, act_post(), e);
    $display("%s ir=%h pc=%h stall_o=%b valid=%b type=%h ra=%h imm=%h wen=%b exc=%b pc_o=%h",
             nm, i, p, stall_o, valid_o, type_o, ra_o, imm_o, wen_o, exc_o, pc_o);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_state", {78'h0, stall_o, act_post() == bub(32'h0)}, {78'h0, 1'b0, 1'b1});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = mkv({32'h0, 32'h2031000A}, 32'h100, 0, 0, 0, 4'h0, 0, 4'h0, {1'b0, 4'h1, 4'h0},
                   post_f(1, 4'h2, 4'h0, 4'h3, 4'h1, 4'h0, 32'h5, 1, 0, 32'h100));
    vecs[1]  = mkv({32'hDEADBEEF, 32'h50200001}, 32'h104, 0, 0, 0, 4'h0, 0, 4'h0, 9'h0,
                   post_f(1, 4'h5, 4'h0, 4'h2, 4'h0, 4'h0, 32'hDEADBEEF, 1, 0, 32'h104));
    vecs[2]  = mkv({32'h12345678, 32'h50200FFE}, 32'h108, 0, 0, 0, 4'h0, 0, 4'h0, 9'h0,
                   post_f(1, 4'h5, 4'h0, 4'h2, 4'h0, 4'h0, 32'hFFFFFFFF, 1, 0, 32'h108));
    vecs[3]  = mkv({32'h0, 32'h70000000}, 32'h10C, 0, 0, 0, 4'h0, 0, 4'h0, 9'h0,
                   post_f(1, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 0, 1, 32'h10C));
    vecs[4]  = mkv(64'h0, 32'h110, 0, 0, 0, 4'h0, 0, 4'h0, 9'h0, bub(32'h10C));
    vecs[5]  = mkv({32'h0, 32'h20540002}, 32'h114, 0, 0, 1, 4'h4, 0, 4'h0, {1'b1, 4'h4, 4'h0},
                   bub(32'h10C));
    vecs[6]  = mkv({32'h0, 32'h20540002}, 32'h114, 0, 0, 0, 4'h0, 1, 4'h4, {1'b1, 4'h4, 4'h0},
                   bub(32'h10C));
    vecs[7]  = mkv({32'h0, 32'h20540002}, 32'h114, 0, 0, 0, 4'h0, 1, 4'h0, {1'b0, 4'h4, 4'h0},
                   post_f(1, 4'h2, 4'h0, 4'h5, 4'h4, 4'h0, 32'h1, 1, 0, 32'h114));
    vecs[8]  = mkv({32'h0, 32'h10150000}, 32'h118, 0, 0, 0, 4'h0, 0, 4'h0, {1'b1, 4'h5, 4'h0},
                   bub(32'h114));
    vecs[9]  = mkv({32'h0, 32'h10150000}, 32'h118, 0, 0, 0, 4'h0, 0, 4'h0, {1'b0, 4'h5, 4'h0},
                   post_f(1, 4'h1, 4'h0, 4'h1, 4'h5, 4'h0, 32'h0, 1, 0, 32'h118));
    vecs[10] = mkv({32'h0, 32'h30120000}, 32'h11C, 0, 0, 0, 4'h0, 0, 4'h0, {1'b1, 4'h2, 4'h1},
                   bub(32'h118));
    vecs[11] = mkv({32'h0, 32'h30120000}, 32'h11C, 0, 0, 0, 4'h0, 0, 4'h0, {1'b0, 4'h2, 4'h1},
                   post_f(1, 4'h3, 4'h0, 4'h1, 4'h2, 4'h0, 32'h0, 0, 0, 32'h11C));
    vecs[12] = mkv({32'h0, 32'h20310002}, 32'h120, 1, 0, 0, 4'h0, 0, 4'h0, {1'b1, 4'h1, 4'h0},
                   post_f(1, 4'h3, 4'h0, 4'h1, 4'h2, 4'h0, 32'h0, 0, 0, 32'h11C));
    vecs[13] = mkv({32'h0, 32'h20310002}, 32'h124, 1, 1, 0, 4'h0, 0, 4'h0, {1'b1, 4'h1, 4'h0},
                   bub(32'h11C));
    vecs[14] = mkv({32'h0, 32'h10000000}, 32'h128, 0, 0, 0, 4'h0, 1, 4'h0, {1'b1, 4'h0, 4'h0},
                   bub(32'h11C));
    vecs[15] = mkv({32'h0, 32'h10000000}, 32'h128, 0, 1, 0, 4'h0, 1, 4'h0, 9'h0,
                   bub(32'h11C));
    vecs[16] = mkv({32'h0, 32'hF0000000}, 32'h12C, 0, 0, 1, 4'h0, 0, 4'h0, 9'h0,
                   post_f(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 0, 1, 32'h12C));

    rst = 1'b1; ir = 64'h0; pc = 32'h0; st = 1'b0; fl = 1'b0; fb_en = 1'b0;
    tb_exv = 1'b0; tb_exr = 4'h0; tb_mv = 1'b0; tb_mr = 4'h0;
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < NV; i++)
      apply($sformatf("vec%0d", i), vecs[i].ir, vecs[i].pc, vecs[i].st, vecs[i].fl,
            vecs[i].exv, vecs[i].exr, vecs[i].mv, vecs[i].mr, vecs[i].pre, vecs[i].post);

    // Load r3 then ALU reading r3, with EX/MEM fed back from ID/EX.
    do_reset();
    fb_en = 1'b1;
    apply("lu_load", {32'h0, 32'h40310000}, 32'h200, 0, 0, 0, 4'h0, 0, 4'h0,
          {1'b0, 4'h1, 4'h0}, post_f(1, 4'h4, 4'h0, 4'h3, 4'h1, 4'h0, 32'h0, 1, 0, 32'h200));
    for (int k = 0; k < 3; k++)
      apply($sformatf("lu_stall%0d", k), {32'h0, 32'h10243000}, 32'h204, 0, 0, 0, 4'h0, 0, 4'h0,
            {1'b1, 4'h4, 4'h3}, bub(32'h200));
    apply("lu_alu", {32'h0, 32'h10243000}, 32'h204, 0, 0, 0, 4'h0, 0, 4'h0,
          {1'b0, 4'h4, 4'h3}, post_f(1, 4'h1, 4'h0, 4'h2, 4'h4, 4'h3, 32'h0, 1, 0, 32'h204));
    apply("lu_after", 64'h0, 32'h208, 0, 0, 0, 4'h0, 0, 4'h0, 9'h0, bub(32'h204));
    fb_en = 1'b0;

    // Asynchronous reset while a hazard stall is in progress.
    apply("ar_fill", {32'h0, 32'h20310002}, 32'h300, 0, 0, 0, 4'h0, 0, 4'h0,
          {1'b0, 4'h1, 4'h0}, post_f(1, 4'h2, 4'h0, 4'h3, 4'h1, 4'h0, 32'h1, 1, 0, 32'h300));
    @(negedge clk);
    ir = {32'h0, 32'h10130000}; pc = 32'h304;
    #1;
    chk("ar_stall_before", {86'h0, stall_o}, {86'h0, 1'b1});
    rst = 1'b1;
    #1;
    chk("ar_outputs", act_post(), bub(32'h0));
    chk("ar_stall_after", {86'h0, stall_o}, {86'h0, 1'b0});
    $display("async_reset stall_o=%b valid=%b pc_o=%h", stall_o, valid_o, pc_o);
    @(negedge clk);
    rst = 1'b0;
    ir = 64'h0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish by 100000");
    $fatal(1);
  end

endmodule
